// File: rtl/synaptic_spike_delay_line_pkg.sv
// rtl/synaptic_spike_delay_line_pkg.sv - shared SNN constants and delay helper
// Purpose: lane count, delay field width and max-delay helper for the SNN datapath.
// Lane packing on all multi-lane buses: lane i occupies [i*W +: W].
package snn_pkg;

  localparam int SNN_M       = 4;
  localparam int SNN_DELAY_W = 2;

  // Largest delay, in timesteps, that a dw-bit delay field can encode.
  function automatic int max_delay(input int dw);
    return (1 << dw) - 1;
  endfunction

endpackage

// File: rtl/synaptic_spike_delay_line_if.sv
// rtl/synaptic_spike_delay_line_if.sv - spike/delay bus between driver and delay line
// Purpose: groups the timestep, spike and delay-configuration signals.
// Signals: enable, input_spikes[M], delays[M*DW], delays_load (driver -> delay line);
//          delayed_spikes[M], spikes_valid, pending (delay line -> consumer).
interface synaptic_spike_delay_line_if
  import snn_pkg::*;
#(
  parameter int M  = SNN_M,
  parameter int DW = SNN_DELAY_W
);

  logic              enable;
  logic [M-1:0]      input_spikes;
  logic [M*DW-1:0]   delays;
  logic              delays_load;
  logic [M-1:0]      delayed_spikes;
  logic              spikes_valid;
  logic              pending;

  modport master (
    output enable, input_spikes, delays, delays_load,
    input  delayed_spikes, spikes_valid, pending
  );

  modport slave (
    input  enable, input_spikes, delays, delays_load,
    output delayed_spikes, spikes_valid, pending
  );

endinterface

// File: rtl/synaptic_spike_delay_line_tap.sv
// rtl/synaptic_spike_delay_line_tap.sv - one synapse lane: spike history and delay tap
// Purpose: holds the last MAX_DELAY spikes of one lane and emits the one selected by delay.
// Ports: clk, reset (sync, active-high), step (advance one timestep), flush (clear history),
//        spike_in, delay[DW-1:0], spike_out (registered), busy (history non-empty).
module spike_delay_tap
  import snn_pkg::*;
#(
  parameter int DW = SNN_DELAY_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          flush,
  input  logic          spike_in,
  input  logic [DW-1:0] delay,
  output logic          spike_out,
  output logic          busy
);

  localparam int MD = max_delay(DW);

  logic [MD-1:0] r_hist;
  logic          r_spike_out;
  logic [MD-1:0] w_next;
  logic [MD:0]   w_taps;

  // Tap k of w_taps is the spike from k steps ago; tap 0 is the live input,
  // so a delay of d selects w_taps[d] with no special case for d == 0.
  assign w_taps = {r_hist, spike_in};

  always_comb begin
    w_next    = r_hist << 1;
    w_next[0] = spike_in;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_hist      <= '0;
      r_spike_out <= 1'b0;
    end else if (step) begin
      r_spike_out <= w_taps[delay];
      r_hist      <= w_next;
    end
  end

  assign spike_out = r_spike_out;
  assign busy      = |r_hist;

endmodule

// File: rtl/synaptic_spike_delay_line.sv
// rtl/synaptic_spike_delay_line.sv - per-synapse programmable axonal delay line
// Purpose: re-emits each presynaptic spike delayed by its lane's 0..MAX_DELAY timesteps.
// Ports: clk, reset (sync, active-high), bus (slave): enable, input_spikes, delays,
//        delays_load in; delayed_spikes, spikes_valid, pending out.
module synaptic_spike_delay_line
  import snn_pkg::*;
#(
  parameter int M  = SNN_M,
  parameter int DW = SNN_DELAY_W
) (
  input logic                         clk,
  input logic                         reset,
  synaptic_spike_delay_line_if.slave  bus
);

  logic [M*DW-1:0] r_delay_reg;
  logic            r_spikes_valid;
  logic            w_step;
  logic [M-1:0]    w_spike_out;
  logic [M-1:0]    w_busy;

  // A load in the same cycle as a timestep discards that timestep entirely.
  assign w_step = bus.enable && !bus.delays_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_delay_reg    <= '0;
      r_spikes_valid <= 1'b0;
    end else begin
      if (bus.delays_load) begin
        r_delay_reg <= bus.delays;
      end
      r_spikes_valid <= w_step;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_lane
    spike_delay_tap #(
      .DW (DW)
    ) u_tap (
      .clk       (clk),
      .reset     (reset),
      .step      (w_step),
      .flush     (bus.delays_load),
      .spike_in  (bus.input_spikes[i]),
      .delay     (r_delay_reg[i*DW +: DW]),
      .spike_out (w_spike_out[i]),
      .busy      (w_busy[i])
    );
  end

  assign bus.delayed_spikes = w_spike_out;
  assign bus.spikes_valid   = r_spikes_valid;
  assign bus.pending        = |w_busy;

endmodule
